// File: rtl/mac_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mac_vec_pipe
//  Purpose  : Pipelined signed vector MAC, f = x + sum(a[i]*b[i]), with
//             run-time vector length, valid/ready backpressure, selectable
//             saturating or wrapping accumulate and a sticky per-vector
//             overflow flag.
//             Optional macro MAC_DBG_CNT_EN adds result/overflow counters
//             (dbg_vec_cnt, dbg_ovf_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
module mac_vec_pipe #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 16,
    parameter int MUL_STAGES = 2,
    parameter int MAX_VEC    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_W-1:0]          a,
    input  logic signed [DATA_W-1:0]          b,
    input  logic signed [DATA_W-1:0]          x,
    input  logic [$clog2(MAX_VEC+1)-1:0]      vec_len,
    input  logic                              sat_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [ACC_W-1:0]           out_result,
    output logic                              out_ovf
`ifdef MAC_DBG_CNT_EN
    ,
    output logic [15:0]                       dbg_vec_cnt,
    output logic [15:0]                       dbg_ovf_cnt
`endif
);

    localparam int                       c_CNT_W   = $clog2(MAX_VEC + 1);
    localparam logic [c_CNT_W-1:0]       c_MAX_LEN = c_CNT_W'(MAX_VEC);
    localparam logic [c_CNT_W-1:0]       c_ONE     = c_CNT_W'(1);
    localparam logic signed [ACC_W-1:0]  c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Element tracking for the vector currently being accepted
    logic [c_CNT_W-1:0]        r_elem_cnt;
    logic [c_CNT_W-1:0]        r_len;
    logic                      r_sat_vec;

    // Stage 0: input register
    logic                      r_s0_valid;
    logic                      r_s0_first;
    logic                      r_s0_last;
    logic                      r_s0_sat;
    logic signed [DATA_W-1:0]  r_s0_a;
    logic signed [DATA_W-1:0]  r_s0_b;
    logic signed [ACC_W-1:0]   r_s0_bias;

    // Multiplier stages 1..MUL_STAGES
    logic                      r_p_valid [1:MUL_STAGES];
    logic                      r_p_first [1:MUL_STAGES];
    logic                      r_p_last  [1:MUL_STAGES];
    logic                      r_p_sat   [1:MUL_STAGES];
    logic signed [ACC_W-1:0]   r_p_bias  [1:MUL_STAGES];
    logic signed [ACC_W-1:0]   r_p_prod  [1:MUL_STAGES];

    // Accumulator state
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_ovf;

    logic                      w_stall;
    logic                      w_accept;
    logic                      w_first;
    logic                      w_last;
    logic                      w_beat_sat;
    logic [c_CNT_W-1:0]        w_len_eff;
    logic [c_CNT_W-1:0]        w_cur_len;
    logic signed [2*DATA_W-1:0] w_s0_prod;
    logic signed [ACC_W-1:0]   w_op_a;
    logic signed [ACC_W-1:0]   w_op_b;
    logic signed [ACC_W:0]     w_sum;
    logic                      w_elem_ovf;
    logic                      w_ovf_next;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic                      w_m_valid;

    // A held result blocks the whole pipeline; only then is input refused
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & in_ready;

    // Beat classification and first-beat length clamping
    always_comb begin
        w_first    = (r_elem_cnt == '0);
        w_len_eff  = vec_len;
        if (vec_len == '0) begin
            w_len_eff = c_ONE;
        end else if (vec_len > c_MAX_LEN) begin
            w_len_eff = c_MAX_LEN;
        end
        w_cur_len  = w_first ? w_len_eff : r_len;
        w_last     = (r_elem_cnt == (w_cur_len - c_ONE));
        w_beat_sat = w_first ? sat_mode : r_sat_vec;
        w_s0_prod  = r_s0_a * r_s0_b;
    end

    // Element counter and per-vector length/mode latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_elem_cnt <= '0;
            r_len      <= c_ONE;
            r_sat_vec  <= 1'b0;
        end else if (w_accept) begin
            r_elem_cnt <= w_last ? '0 : (r_elem_cnt + c_ONE);
            if (w_first) begin
                r_len     <= w_len_eff;
                r_sat_vec <= sat_mode;
            end
        end
    end

    // Input register and multiplier pipeline; tags and bias ride with each beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_sat   <= 1'b0;
            r_s0_a     <= '0;
            r_s0_b     <= '0;
            r_s0_bias  <= '0;
            for (int i = 1; i <= MUL_STAGES; i++) begin
                r_p_valid[i] <= 1'b0;
                r_p_first[i] <= 1'b0;
                r_p_last[i]  <= 1'b0;
                r_p_sat[i]   <= 1'b0;
                r_p_bias[i]  <= '0;
                r_p_prod[i]  <= '0;
            end
        end else if (!w_stall) begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_first <= w_first;
                r_s0_last  <= w_last;
                r_s0_sat   <= w_beat_sat;
                r_s0_a     <= a;
                r_s0_b     <= b;
                r_s0_bias  <= ACC_W'(x);
            end
            r_p_valid[1] <= r_s0_valid;
            r_p_first[1] <= r_s0_first;
            r_p_last[1]  <= r_s0_last;
            r_p_sat[1]   <= r_s0_sat;
            r_p_bias[1]  <= r_s0_bias;
            r_p_prod[1]  <= ACC_W'(w_s0_prod);
            for (int i = 2; i <= MUL_STAGES; i++) begin
                r_p_valid[i] <= r_p_valid[i-1];
                r_p_first[i] <= r_p_first[i-1];
                r_p_last[i]  <= r_p_last[i-1];
                r_p_sat[i]   <= r_p_sat[i-1];
                r_p_bias[i]  <= r_p_bias[i-1];
                r_p_prod[i]  <= r_p_prod[i-1];
            end
        end
    end

    // Accumulate at ACC_W+1 bits; overflow when like-signed operands flip sign
    always_comb begin
        w_m_valid  = r_p_valid[MUL_STAGES];
        w_op_a     = r_p_first[MUL_STAGES] ? r_p_bias[MUL_STAGES] : r_acc;
        w_op_b     = r_p_prod[MUL_STAGES];
        w_sum      = (ACC_W+1)'(w_op_a) + (ACC_W+1)'(w_op_b);
        w_elem_ovf = (w_op_a[ACC_W-1] == w_op_b[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != w_op_a[ACC_W-1]);
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_elem_ovf && r_p_sat[MUL_STAGES]) begin
            w_acc_next = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
        end
        w_ovf_next = (r_p_first[MUL_STAGES] ? 1'b0 : r_ovf) | w_elem_ovf;
    end

    // Accumulator update and result register with hold-until-taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
        end else if (!w_stall) begin
            out_valid <= w_m_valid & r_p_last[MUL_STAGES];
            if (w_m_valid) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
                if (r_p_last[MUL_STAGES]) begin
                    out_result <= w_acc_next;
                    out_ovf    <= w_ovf_next;
                end
            end
        end
    end

`ifdef MAC_DBG_CNT_EN
    // Debug counters: results delivered and results delivered with overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_vec_cnt <= '0;
            dbg_ovf_cnt <= '0;
        end else if (out_valid && out_ready) begin
            dbg_vec_cnt <= dbg_vec_cnt + 16'd1;
            if (out_ovf) begin
                dbg_ovf_cnt <= dbg_ovf_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/mac_vec_pipe.md
Name: mac_vec_pipe

Overview:
- Parametrised successor to the fixed-function vector MAC. Computes a bias plus a dot product over one vector of signed operand pairs, f = x + sum(a[i]*b[i]).
- Generalises operand width, accumulator width, multiplier depth and vector length, and takes vector length at run time.
- Adds valid/ready backpressure, a selectable saturating or wrapping accumulate, and a per-vector overflow flag.
- Sits between the operand-streaming controller and the result writeback in the neural-net datapath.

Parameters:
DATA_W, 8, width of signed operands a, b and bias x
ACC_W, 16, signed accumulator/result width (ACC_W >= 2*DATA_W)
MUL_STAGES, 2, register stages inside the in-house multiplier (1..6)
MAX_VEC, 8, maximum vector length; counters sized $clog2(MAX_VEC+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat
a  in  DATA_W  signed operand
b  in  DATA_W  signed operand
x  in  DATA_W  signed bias, sampled on first beat of a vector only
vec_len  in  $clog2(MAX_VEC+1)  vector length, sampled on first beat only
sat_mode  in  1  1 = saturate, 0 = wrap; sampled on first beat only
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  ACC_W  signed vector result
out_ovf  out  1  overflow or saturation occurred in this vector

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, out_result=0, out_ovf=0. All pipeline valids, counters and the accumulator clear, and a partial vector is discarded.
- Stall and accept: stall = out_valid & !out_ready. in_ready = !stall. A beat is accepted when in_valid & in_ready. When stall is high, every pipeline register and counter holds.
- First-beat sampling: on the first beat (element counter == 0), latch x sign-extended to ACC_W, latch sat_mode, and latch len.
  - len = vec_len, except vec_len == 0 gives 1 and vec_len > MAX_VEC gives MAX_VEC.
  - The element counter wraps to 0 after len-1.
- Pipeline:
  - Stage 0: input register.
  - Stages 1..MUL_STAGES: multiplier, full 2*DATA_W signed product, sign-extended to ACC_W.
  - Final stage: accumulate.
  - The valid bit and the first/last tags travel with the data.
- Accumulate: sum = (first ? bias : acc) + product, computed at ACC_W+1 bits. Overflow = the two operand signs are equal and the result sign differs.
  - Wrap mode: acc = sum[ACC_W-1:0].
  - Saturate mode: acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) by the sign of the true sum. Later elements continue from the clamped value.
  - The sticky ovf is cleared on the first element and ORed on each element.
- Result: on the last element, out_result <= acc_next, out_ovf <= ovf_next, out_valid <= 1.
  - Latency: last beat accepted in cycle t gives out_valid in cycle t+MUL_STAGES+2, absent stalls.
- Output hold: out_valid stays 1 and out_result/out_ovf stay stable until out_valid & out_ready.
  - If a new result completes in the same cycle the old one is taken, out_valid stays 1 with the new data.
  - Otherwise out_valid drops to 0.
- Throughput: one beat per cycle sustained with out_ready=1. vec_len=1 gives one result per cycle.
- Vector boundaries: back-to-back vectors need no bubble. The first beat of a vector may be accepted in the cycle after the previous last beat.
- Run-time inputs: vec_len, sat_mode and x are ignored on non-first beats.

Optional Feature:
- Macro: MAC_DBG_CNT_EN.
- When defined, adds two outputs:
  - dbg_vec_cnt (16 bits): increments on each result handshake.
  - dbg_ovf_cnt (16 bits): increments on each result handshake with out_ovf=1.
  - Both counters wrap at 16 bits and clear on reset.
- When undefined, these ports and their logic are absent. Datapath behaviour is identical either way.

Test Plan:
1. Basic vector with defaults and MUL_STAGES=2. vec_len=3, x=5, pairs (2,3), (-4,5), (7,-1), out_ready=1 -> out_result=-16 (0xFFF0), out_ovf=0, out_valid exactly 4 cycles after the last beat.
2. Overflow in wrap mode. vec_len=4, x=0, four pairs of (127,127), sat_mode=0 -> out_result=-1020 (0xFC04), out_ovf=1.
3. Overflow in saturate mode. Same stimulus as 2 with sat_mode=1 -> out_result=32767, out_ovf=1. With the debug macro defined, dbg_ovf_cnt increments by 1 per case.
4. Backpressure. Hold out_ready=0 while a result is valid -> in_ready=0, out_result held stable for 5 cycles, in_valid beats not consumed. Raise out_ready -> result taken, the next vector completes with the correct value.
5. Back-to-back and length clamps.
   - vec_len=1, x=1, beats (i,i) for i=0..7 streamed every cycle -> results 1, 2, 5, 10, 17, 26, 37, 50 on consecutive cycles.
   - vec_len=0 -> treated as length 1.
   - vec_len=15 -> treated as length 8.
6. Reset mid-vector. Apply reset after 2 of 4 beats -> out_valid=0 and no result emitted. A following vec_len=2, x=0, pairs (3,3), (1,1) vector -> out_result=10.
